// File: rtl/ysyx_reg_wb.sv
// Commit-write buffer: queues register writebacks, drains one per cycle into the
// register file, and exposes pending/bypass lookups. Optional macro: YSYX_WB_BYPASS_EN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif

module ysyx_reg_wb #(
  parameter int XLEN    = `YSYX_XLEN,
  parameter int REG_LEN = `YSYX_REG_LEN,
  parameter int DEPTH   = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  output logic                     write_en,
  output logic [4:0]               waddr,
  output logic [XLEN-1:0]          wdata,
  input  logic                     hold,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [XLEN-1:0]          fwd1_data,
  output logic [XLEN-1:0]          fwd2_data,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      r_wptr, r_rptr;
  logic [4:0]       r_rd   [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];

  logic             w_full, w_empty, w_push, w_pop;
  logic [PW-1:0]    w_idx;
  logic             w_hit1, w_hit2;
  logic [XLEN-1:0]  w_d1, w_d2;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW-1:0] == r_rptr[PW-1:0]) && (r_wptr[PW] != r_rptr[PW]);
  assign in_ready = !w_full;
  assign empty    = w_empty;
  assign count    = r_wptr - r_rptr;
  // x0 writes are handshaken but never stored
  assign w_push   = in_valid && in_ready && (in_rd[REG_LEN-1:0] != '0);
  assign w_pop    = !w_empty && !hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      write_en <= w_pop;
      if (w_pop) begin
        waddr <= r_rd[r_rptr[PW-1:0]];
        wdata <= r_data[r_rptr[PW-1:0]];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_rd[r_wptr[PW-1:0]]   <= in_rd;
      r_data[r_wptr[PW-1:0]] <= in_data;
    end
  end

  // Oldest first so later (younger) matches override: write stage, then head..tail
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_d1   = '0;
    w_d2   = '0;
    w_idx  = '0;
    if (write_en && waddr[REG_LEN-1:0] == rs1[REG_LEN-1:0]) begin
      w_hit1 = 1'b1;
      w_d1   = wdata;
    end
    if (write_en && waddr[REG_LEN-1:0] == rs2[REG_LEN-1:0]) begin
      w_hit2 = 1'b1;
      w_d2   = wdata;
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr[PW-1:0] + PW'(k);
      if ((PW+1)'(k) < count) begin
        if (r_rd[w_idx][REG_LEN-1:0] == rs1[REG_LEN-1:0]) begin
          w_hit1 = 1'b1;
          w_d1   = r_data[w_idx];
        end
        if (r_rd[w_idx][REG_LEN-1:0] == rs2[REG_LEN-1:0]) begin
          w_hit2 = 1'b1;
          w_d2   = r_data[w_idx];
        end
      end
    end
    if (rs1[REG_LEN-1:0] == '0) begin
      w_hit1 = 1'b0;
      w_d1   = '0;
    end
    if (rs2[REG_LEN-1:0] == '0) begin
      w_hit2 = 1'b0;
      w_d2   = '0;
    end
  end

  assign pend1 = w_hit1;
  assign pend2 = w_hit2;

`ifdef YSYX_WB_BYPASS_EN
  assign fwd1_hit  = w_hit1;
  assign fwd2_hit  = w_hit2;
  assign fwd1_data = w_d1;
  assign fwd2_data = w_d2;
`else
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_ysyx_reg_wb.sv
// Scoreboard bench for ysyx_reg_wb: a queue-level reference model predicts
// occupancy, lookups and the write stream; a negedge monitor compares.
module tb_ysyx_reg_wb;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_data = '0;
  logic        write_en;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        hold = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic        pend1, pend2;
  logic        empty;
  logic [2:0]  count;

  ysyx_reg_wb #(.XLEN(32), .REG_LEN(5), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .write_en(write_en), .waddr(waddr), .wdata(wdata), .hold(hold),
    .rs1(rs1), .rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .pend1(pend1), .pend2(pend2), .empty(empty), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  ent_t        exp_wr[$];
  ent_t        m_e, s_e;
  bit          ws_v = 0;
  logic [4:0]  ws_rd = '0;
  logic [31:0] ws_d = '0;
  int          total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [4:0] a, output bit hit, output logic [31:0] d);
    hit = 0;
    d   = '0;
    if (a == 0) return;
    if (ws_v && ws_rd == a) begin hit = 1; d = ws_d; end
    foreach (mq[i]) if (mq[i].rd == a) begin hit = 1; d = mq[i].d; end
  endfunction

  // reference model: a plain FIFO plus one-cycle write stage
  always @(posedge clock) begin
    if (reset) begin
      bit acc, pp;
      acc  = in_valid && (mq.size() < DEPTH);
      pp   = (mq.size() > 0) && !hold;
      ws_v = pp;
      if (pp) begin
        m_e   = mq.pop_front();
        ws_rd = m_e.rd;
        ws_d  = m_e.d;
      end
      if (acc && in_rd != 0) begin
        mq.push_back('{in_rd, in_data});
        exp_wr.push_back('{in_rd, in_data});
      end
    end
  end

  always @(negedge reset) begin
    mq.delete();
    exp_wr.delete();
    ws_v  = 0;
    ws_rd = '0;
    ws_d  = '0;
  end

  always @(negedge clock) begin
    bit h1, h2;
    logic [31:0] d1, d2;
    lookup(rs1, h1, d1);
    lookup(rs2, h2, d2);
    chk("write_en", write_en, ws_v);
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("pend1", pend1, h1);
    chk("pend2", pend2, h2);
`ifdef YSYX_WB_BYPASS_EN
    chk("fwd1_hit", fwd1_hit, h1);
    chk("fwd2_hit", fwd2_hit, h2);
    if (h1) chk("fwd1_data", fwd1_data, d1);
    if (h2) chk("fwd2_data", fwd2_data, d2);
`else
    chk("fwd1_hit", fwd1_hit, 0);
    chk("fwd1_data", fwd1_data, 0);
    chk("fwd2_hit", fwd2_hit, 0);
    chk("fwd2_data", fwd2_data, 0);
`endif
    if (write_en) begin
      if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        s_e = exp_wr.pop_front();
        chk("waddr", waddr, s_e.rd);
        chk("wdata", wdata, s_e.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input bit v, input logic [4:0] rd, input logic [31:0] d, input bit h);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    hold     = h;
  endtask

  initial begin
    #12;
    chk("rst_write_en", write_en, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 1);
    #10 reset = 1'b1;
    cyc();

    // single write, minimum latency
    req(1, 5'd5, 32'hA5A5A5A5, 0);
    cyc();
    req(0, 0, 0, 0);
    repeat (3) cyc();

    // fill under hold, 5th request stalls, then drain in order
    for (int i = 1; i <= 4; i++) begin
      req(1, 5'(i), 32'h100 + i, 1);
      cyc();
    end
    req(1, 5'd9, 32'h999, 1);
    repeat (3) cyc();
    chk("full_count", count, DEPTH);
    chk("full_ready", in_ready, 0);
    req(0, 0, 0, 0);
    repeat (6) cyc();

    // same-rd stacking and youngest-data lookup
    rs1 = 5'd7;
    req(1, 5'd7, 32'h11, 1); cyc();
    req(1, 5'd7, 32'h22, 1); cyc();
    req(0, 0, 0, 1);
    chk("rd7_pend1", pend1, 1);
`ifdef YSYX_WB_BYPASS_EN
    chk("rd7_fwd1_data", fwd1_data, 32'h22);
`else
    chk("rd7_fwd1_hit", fwd1_hit, 0);
`endif
    hold = 0;
    repeat (4) cyc();

    // x0 write is swallowed
    rs1 = 5'd0;
    req(1, 5'd0, 32'hFFFFFFFF, 0); cyc();
    req(0, 0, 0, 0);
    chk("x0_count", count, 0);
    chk("x0_pend1", pend1, 0);
    repeat (2) cyc();

    // full queue then continuous traffic while draining
    for (int i = 0; i < DEPTH; i++) begin
      req(1, 5'(20 + i), $urandom, 1); cyc();
    end
    for (int i = 0; i < 8; i++) begin
      req(1, 5'(10 + i), $urandom, 0); cyc();
    end
    req(0, 0, 0, 0);
    repeat (6) cyc();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      req($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) == 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      cyc();
    end
    req(0, 0, 0, 0);
    repeat (6) cyc();

    // reset mid-operation with three pending entries
    for (int i = 1; i <= 3; i++) begin
      req(1, 5'(i + 3), 32'h300 + i, 1); cyc();
    end
    req(0, 0, 0, 0);
    cyc();
    #2 reset = 1'b0;
    #1;
    chk("midrst_write_en", write_en, 0);
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    repeat (4) cyc();
    chk("postrst_write_en", write_en, 0);

    // final drain, bounded
    for (int i = 0; i < 20 && !(empty && !write_en); i++) cyc();
    @(negedge clock);
    chk("drain_left", exp_wr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
